fetch_unit: RTL

- Instruction fetch stage directly upstream of the integer datapath.
- Generates sequential PCs and issues requests to the instruction memory.
- Buffers returned words with their PCs and presents {instr, pc} to the datapath through a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) carrying the datapath's branch_target, flushes in-flight and buffered fetches, and resumes fetching at the target.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// queues returned words with their PCs, and restarts cleanly on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    localparam int            PW    = $clog2(BUF_DEPTH);
    localparam int            CW    = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [31:0]   rspPc_q, rspPc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] dropCnt_q, dropCnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   bufInstr_q [BUF_DEPTH];
    logic [31:0]   bufPc_q    [BUF_DEPTH];

    logic        reqFire;
    logic        rspTake;
    logic        rspWrite;
    logic        consume;
    logic [31:0] target;

    always_comb begin
        target         = redirect_target & 32'hFFFF_FFFC;
        imem_req_valid = !rst && !redirect &&
                         (({1'b0, outstanding_q} + {1'b0, count_q}) < {1'b0, DEPTH});
        imem_req_addr  = fetchPc_q;
        instr_valid    = (count_q != '0);
        instr          = bufInstr_q[head_q];
        pc             = bufPc_q[head_q];

        reqFire  = imem_req_valid && imem_req_ready;
        // An unsolicited response is ignored so the credit count cannot underflow.
        rspTake  = imem_rsp_valid && (outstanding_q != '0);
        rspWrite = rspTake && !redirect && (dropCnt_q == '0);
        consume  = instr_valid && instr_ready;

        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        dropCnt_d     = dropCnt_q;
        outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspTake);

        if (redirect) begin
            fetchPc_d = target;
            rspPc_d   = target;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            // Every request still in flight after this edge is stale, pending drops included.
            dropCnt_d = outstanding_q - CW'(rspTake);
        end else begin
            if (reqFire) fetchPc_d = fetchPc_q + 32'd4;
            if (rspTake && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CW'(1);
            if (rspWrite) begin
                tail_d  = tail_q + PW'(1);
                rspPc_d = rspPc_q + 32'd4;
            end
            if (consume) head_d = head_q + PW'(1);
            count_d = count_q + CW'(rspWrite) - CW'(consume);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                bufInstr_q[i] <= '0;
                bufPc_q[i]    <= '0;
            end
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            if (rspWrite) begin
                bufInstr_q[tail_q] <= imem_rsp_data;
                bufPc_q[tail_q]    <= rspPc_q;
            end
        end
    end

    // A response with nothing outstanding means the memory and this block disagree.
    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding_q != '0));

endmodule
